// File: rtl/fb_slave_pkg.sv
// Shared constants and types for the FreeDM-bus slave receive path.
// The receive state machine, the slot scheduler and the TX substitution
// path all use these segment lengths, so they live in one place.
package fb_slave_pkg;

  // Default nibble lengths of each receive segment
  localparam int NUMB_NIB_DEF       = 2;
  localparam int DELAY_NIB_DEF      = 4;
  localparam int DIST_NIB_DEF       = 8;
  localparam int DDIST_NIB_DEF      = 8;
  localparam int DATA_HDR_NIB_DEF   = 4;
  localparam int SLOT_HDR_NIB_DEF   = 1;
  localparam int SLAVE_DATA_NIB_DEF = 16;
  localparam int SLAVE_CRC_NIB_DEF  = 4;
  localparam int FRM_CRC_NIB_DEF    = 8;
  localparam int ABORT_NIB_DEF      = 8;

  localparam int SEG_CNT_W  = 16;
  localparam int SLOT_IDX_W = 8;

  // Which segment length the shared counter is compared against
  typedef enum logic [3:0] {
    SegNone,
    SegNumb,
    SegDelay,
    SegDist,
    SegDDist,
    SegHdr,
    SegSlaveData,
    SegSlaveCrc,
    SegFrmCrc
  } seg_sel_e;

  // Segment-boundary strobes handed to the receive state machine
  typedef struct packed {
    logic slaveIdStart;
    logic delayMeasStart;
    logic distStateEnd;
    logic delayDistStateEnd;
    logic slaveDataStart;
    logic slaveDataEnd;
    logic slaveCrcEnd;
    logic dataFrameEnd;
    logic frmCrcStateEnd;
  } seg_strobe_t;

endpackage

// File: rtl/fb_seg_counter.sv
// Saturating segment nibble counter with enable, synchronous clear and a
// terminal-compare flag.
// Ports:
//   MRxClk, Reset   clock, async active-high reset
//   En              advance by one (saturates at all-ones)
//   Clr             synchronous clear, wins over En
//   CmpLen          segment length; AtEnd is high when Cnt == CmpLen-1
//   Cnt             current count
//   AtEnd           terminal-compare flag (combinational)
module fb_seg_counter
  import fb_slave_pkg::*;
#(
  parameter int W = SEG_CNT_W
) (
  input  logic         MRxClk,
  input  logic         Reset,
  input  logic         En,
  input  logic         Clr,
  input  logic [W-1:0] CmpLen,
  output logic [W-1:0] Cnt,
  output logic         AtEnd
);

  always_ff @(posedge MRxClk or posedge Reset) begin
    if (Reset)                   Cnt <= '0;
    else if (Clr)                Cnt <= '0;
    else if (En && (Cnt != '1))  Cnt <= Cnt + W'(1);
  end

  assign AtEnd = (Cnt == (CmpLen - W'(1)));

endmodule

// File: rtl/fb_slave_slot_sched.sv
// Nibble-count and slot scheduler for the FreeDM-bus slave receive FSM.
// One shared segment counter times every receive segment; the compare
// length is selected by the active one-hot state. Produces the segment
// boundary strobes, tracks the slave slot on the wire, flags this node's
// own slot, and raises a one-cycle abort on a long MRxDV gap mid-frame.
// Ports:
//   MRxClk, Reset            clock, async active-high reset
//   MRxDV                    nibble valid
//   State*                   one-hot receive FSM state (StateSlaveData is a pair)
//   CfgSlaveNum, CfgMyID     slaves per frame (latched at preamble), own slot
//   SegCnt, SlaveIdx         nibbles elapsed in segment, current slot
//   SlaveIDStart..FrmCrcStateEnd  strobes to the receive FSM
//   IsLastSlave              current slot is the last one (valid with SlaveCrcEnd)
//   MySlot                   own slot data/CRC on the wire
//   RxAbort                  registered one-cycle abort pulse
module fb_slave_slot_sched
  import fb_slave_pkg::*;
#(
  parameter int NUMB_NIB       = NUMB_NIB_DEF,
  parameter int DELAY_NIB      = DELAY_NIB_DEF,
  parameter int DIST_NIB       = DIST_NIB_DEF,
  parameter int DDIST_NIB      = DDIST_NIB_DEF,
  parameter int DATA_HDR_NIB   = DATA_HDR_NIB_DEF,
  parameter int SLOT_HDR_NIB   = SLOT_HDR_NIB_DEF,
  parameter int SLAVE_DATA_NIB = SLAVE_DATA_NIB_DEF,
  parameter int SLAVE_CRC_NIB  = SLAVE_CRC_NIB_DEF,
  parameter int FRM_CRC_NIB    = FRM_CRC_NIB_DEF,
  parameter int ABORT_NIB      = ABORT_NIB_DEF
) (
  input  logic                  MRxClk,
  input  logic                  Reset,
  input  logic                  MRxDV,
  input  logic                  StateIdle,
  input  logic                  StateFFS,
  input  logic                  StatePreamble,
  input  logic                  StateNumb,
  input  logic                  StateDelay,
  input  logic                  StateDist,
  input  logic                  StateDelayDist,
  input  logic                  StateData,
  input  logic [1:0]            StateSlaveData,
  input  logic                  StateSlaveCrc,
  input  logic                  StateFrmCrc,
  input  logic [7:0]            CfgSlaveNum,
  input  logic [7:0]            CfgMyID,
  output logic [SEG_CNT_W-1:0]  SegCnt,
  output logic [SLOT_IDX_W-1:0] SlaveIdx,
  output logic                  SlaveIDStart,
  output logic                  DelayMeasStart,
  output logic                  DistStateEnd,
  output logic                  DelayDistStateEnd,
  output logic                  SlaveDataStart,
  output logic                  SlaveDataEnd,
  output logic                  SlaveCrcEnd,
  output logic                  IsLastSlave,
  output logic                  DataFrameEnd,
  output logic                  FrmCrcStateEnd,
  output logic                  MySlot,
  output logic                  RxAbort
);

  localparam logic [SEG_CNT_W-1:0] ABORT_LAST = SEG_CNT_W'(ABORT_NIB - 1);

  logic [SLOT_IDX_W-1:0] numLat;
  logic                  firstVisit;
  logic                  aborted;
  logic [SEG_CNT_W-1:0]  abortCnt;

  logic                  slaveDataAny;
  logic                  activeState;
  logic                  noFrame;
  seg_sel_e              segSel;
  logic [SEG_CNT_W-1:0]  hdrLen;
  logic [SEG_CNT_W-1:0]  cmpLen;
  logic                  segAtEnd;
  logic                  live;
  seg_strobe_t           stb;
  logic                  segEn;
  logic                  segClr;

  assign slaveDataAny = |StateSlaveData;
  assign activeState  = StateNumb | StateDelay | StateDist | StateDelayDist |
                        StateData | slaveDataAny | StateSlaveCrc | StateFrmCrc;
  // Idle and start-of-frame search both mean no frame is in flight
  assign noFrame      = StateIdle | StateFFS;

  // The first data-state visit carries the frame header; later visits
  // are just the short per-slot header.
  assign hdrLen = firstVisit ? SEG_CNT_W'(DATA_HDR_NIB) : SEG_CNT_W'(SLOT_HDR_NIB);

  always_comb begin
    segSel = SegNone;
    if      (StateNumb)      segSel = SegNumb;
    else if (StateDelay)     segSel = SegDelay;
    else if (StateDist)      segSel = SegDist;
    else if (StateDelayDist) segSel = SegDDist;
    else if (StateData)      segSel = SegHdr;
    else if (slaveDataAny)   segSel = SegSlaveData;
    else if (StateSlaveCrc)  segSel = SegSlaveCrc;
    else if (StateFrmCrc)    segSel = SegFrmCrc;
  end

  always_comb begin
    cmpLen = '0;
    case (segSel)
      SegNumb:      cmpLen = SEG_CNT_W'(NUMB_NIB);
      SegDelay:     cmpLen = SEG_CNT_W'(DELAY_NIB);
      SegDist:      cmpLen = SEG_CNT_W'(DIST_NIB);
      SegDDist:     cmpLen = SEG_CNT_W'(DDIST_NIB);
      SegHdr:       cmpLen = hdrLen;
      SegSlaveData: cmpLen = SEG_CNT_W'(SLAVE_DATA_NIB);
      SegSlaveCrc:  cmpLen = SEG_CNT_W'(SLAVE_CRC_NIB);
      SegFrmCrc:    cmpLen = SEG_CNT_W'(FRM_CRC_NIB);
      default:      cmpLen = '0;
    endcase
  end

  // A stalled nibble or an aborted frame never produces a strobe
  assign live = MRxDV & ~aborted & segAtEnd;

  always_comb begin
    stb                   = '0;
    stb.slaveIdStart      = live & StateNumb;
    stb.delayMeasStart    = live & StateDelay;
    stb.distStateEnd      = live & StateDist;
    stb.delayDistStateEnd = live & StateDelayDist;
    stb.slaveDataStart    = live & StateData & (numLat != '0);
    stb.dataFrameEnd      = live & StateData & (numLat == '0);
    // Both halves of the slave-data pair share one segment; only the
    // second half can close it.
    stb.slaveDataEnd      = live & StateSlaveData[1];
    stb.slaveCrcEnd       = live & StateSlaveCrc;
    stb.frmCrcStateEnd    = live & StateFrmCrc;
  end

  assign segEn  = MRxDV & activeState & ~aborted;
  assign segClr = StatePreamble | (|stb);

  fb_seg_counter #(.W(SEG_CNT_W)) u_segCnt (
    .MRxClk (MRxClk),
    .Reset  (Reset),
    .En     (segEn),
    .Clr    (segClr),
    .CmpLen (cmpLen),
    .Cnt    (SegCnt),
    .AtEnd  (segAtEnd)
  );

  assign SlaveIDStart      = stb.slaveIdStart;
  assign DelayMeasStart    = stb.delayMeasStart;
  assign DistStateEnd      = stb.distStateEnd;
  assign DelayDistStateEnd = stb.delayDistStateEnd;
  assign SlaveDataStart    = stb.slaveDataStart;
  assign SlaveDataEnd      = stb.slaveDataEnd;
  assign SlaveCrcEnd       = stb.slaveCrcEnd;
  assign DataFrameEnd      = stb.dataFrameEnd;
  assign FrmCrcStateEnd    = stb.frmCrcStateEnd;

  // Meaningless when numLat is 0 (compares against 255); only sampled
  // together with SlaveCrcEnd, which cannot occur in a zero-slave frame.
  assign IsLastSlave = (SlaveIdx == (numLat - SLOT_IDX_W'(1)));
  assign MySlot      = (slaveDataAny | StateSlaveCrc) & (SlaveIdx == CfgMyID);

  // Slave count is latched per frame so a config change mid-frame cannot
  // move the frame end. Preamble wins over any (illegal) overlapping state.
  always_ff @(posedge MRxClk or posedge Reset) begin
    if (Reset) begin
      numLat     <= '0;
      SlaveIdx   <= '0;
      firstVisit <= 1'b1;
    end else if (StatePreamble) begin
      numLat     <= CfgSlaveNum;
      SlaveIdx   <= '0;
      firstVisit <= 1'b1;
    end else begin
      if (stb.slaveDataStart)
        firstVisit <= 1'b0;
      if (stb.slaveCrcEnd && !IsLastSlave)
        SlaveIdx <= SlaveIdx + SLOT_IDX_W'(1);
    end
  end

  // Gap watchdog: counts consecutive stalled nibbles inside a frame and
  // pulses RxAbort once when the count lands on ABORT_NIB-1. After that
  // everything is frozen until the next preamble.
  always_ff @(posedge MRxClk or posedge Reset) begin
    if (Reset) begin
      abortCnt <= '0;
      RxAbort  <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      RxAbort <= 1'b0;
      if (StatePreamble) begin
        abortCnt <= '0;
        aborted  <= 1'b0;
      end else if (MRxDV || noFrame) begin
        abortCnt <= '0;
      end else if (activeState && !aborted && (abortCnt != ABORT_LAST)) begin
        abortCnt <= abortCnt + SEG_CNT_W'(1);
        if ((abortCnt + SEG_CNT_W'(1)) == ABORT_LAST) begin
          RxAbort <= 1'b1;
          aborted <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_slave_slot_sched.sv
// Scoreboard bench for fb_slave_slot_sched. Frame tasks push the expected
// per-cycle outputs when they drive a cycle; a negedge monitor pops and
// compares them against the DUT.
module tb_fb_slave_slot_sched;

  localparam int ABORT_NIB = 8;

  localparam int S_IDLE = 0, S_FFS = 1, S_PRE = 2, S_NUMB = 3, S_DELAY = 4,
                 S_DIST = 5, S_DDIST = 6, S_DATA = 7, S_SD0 = 8, S_SD1 = 9,
                 S_SCRC = 10, S_FCRC = 11;

  // Strobe bit positions in obsStb
  localparam int B_SID = 8, B_DMS = 7, B_DSE = 6, B_DDE = 5, B_SDS = 4,
                 B_SDE = 3, B_SCE = 2, B_DFE = 1, B_FCE = 0;

  logic        MRxClk, Reset, MRxDV;
  logic        StateIdle, StateFFS, StatePreamble, StateNumb, StateDelay;
  logic        StateDist, StateDelayDist, StateData, StateSlaveCrc, StateFrmCrc;
  logic [1:0]  StateSlaveData;
  logic [7:0]  CfgSlaveNum, CfgMyID;
  logic [15:0] SegCnt;
  logic [7:0]  SlaveIdx;
  logic        SlaveIDStart, DelayMeasStart, DistStateEnd, DelayDistStateEnd;
  logic        SlaveDataStart, SlaveDataEnd, SlaveCrcEnd, IsLastSlave;
  logic        DataFrameEnd, FrmCrcStateEnd, MySlot, RxAbort;
  logic [8:0]  obsStb;

  fb_slave_slot_sched dut (
    .MRxClk(MRxClk), .Reset(Reset), .MRxDV(MRxDV),
    .StateIdle(StateIdle), .StateFFS(StateFFS), .StatePreamble(StatePreamble),
    .StateNumb(StateNumb), .StateDelay(StateDelay), .StateDist(StateDist),
    .StateDelayDist(StateDelayDist), .StateData(StateData),
    .StateSlaveData(StateSlaveData), .StateSlaveCrc(StateSlaveCrc),
    .StateFrmCrc(StateFrmCrc), .CfgSlaveNum(CfgSlaveNum), .CfgMyID(CfgMyID),
    .SegCnt(SegCnt), .SlaveIdx(SlaveIdx), .SlaveIDStart(SlaveIDStart),
    .DelayMeasStart(DelayMeasStart), .DistStateEnd(DistStateEnd),
    .DelayDistStateEnd(DelayDistStateEnd), .SlaveDataStart(SlaveDataStart),
    .SlaveDataEnd(SlaveDataEnd), .SlaveCrcEnd(SlaveCrcEnd),
    .IsLastSlave(IsLastSlave), .DataFrameEnd(DataFrameEnd),
    .FrmCrcStateEnd(FrmCrcStateEnd), .MySlot(MySlot), .RxAbort(RxAbort)
  );

  assign obsStb = {SlaveIDStart, DelayMeasStart, DistStateEnd, DelayDistStateEnd,
                   SlaveDataStart, SlaveDataEnd, SlaveCrcEnd, DataFrameEnd,
                   FrmCrcStateEnd};

  initial MRxClk = 1'b0;
  always #5 MRxClk = ~MRxClk;

  typedef struct {
    logic [8:0]  stb;
    logic [15:0] seg;
    logic [7:0]  idx;
    logic        my;
    logic        chkLast;
    logic        last;
    logic        abt;
  } want_t;

  want_t sbq[$];
  want_t mon;

  int nTests = 0;
  int nFail  = 0;

  // Expected-schedule state kept by the bench
  logic [15:0] mSeg;
  logic [7:0]  mIdx;
  logic [7:0]  numLat;
  logic [7:0]  myId;
  logic        first;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    nTests++;
    if (obs !== want) begin
      nFail++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, want);
    end
  endtask

  always @(negedge MRxClk) begin
    if (sbq.size() > 0) begin
      mon = sbq.pop_front();
      chk("strobes", 32'(obsStb), 32'(mon.stb));
      chk("SegCnt", 32'(SegCnt), 32'(mon.seg));
      chk("SlaveIdx", 32'(SlaveIdx), 32'(mon.idx));
      chk("MySlot", 32'(MySlot), 32'(mon.my));
      chk("RxAbort", 32'(RxAbort), 32'(mon.abt));
      if (mon.chkLast) chk("IsLastSlave", 32'(IsLastSlave), 32'(mon.last));
    end
  end

  task automatic driveState(input int st);
    StateIdle      = (st == S_IDLE);
    StateFFS       = (st == S_FFS);
    StatePreamble  = (st == S_PRE);
    StateNumb      = (st == S_NUMB);
    StateDelay     = (st == S_DELAY);
    StateDist      = (st == S_DIST);
    StateDelayDist = (st == S_DDIST);
    StateData      = (st == S_DATA);
    StateSlaveData = {st == S_SD1, st == S_SD0};
    StateSlaveCrc  = (st == S_SCRC);
    StateFrmCrc    = (st == S_FCRC);
  endtask

  // Drive one cycle and queue what the DUT must show during it
  task automatic cyc(input int st, input logic dv, input logic [8:0] stb, input logic abt);
    want_t w;
    @(posedge MRxClk); #1;
    driveState(st);
    MRxDV     = dv;
    w.stb     = stb;
    w.seg     = mSeg;
    w.idx     = mIdx;
    w.my      = ((st == S_SD0) || (st == S_SD1) || (st == S_SCRC)) && (mIdx == myId);
    w.chkLast = stb[B_SCE];
    w.last    = (mIdx == numLat - 8'd1);
    w.abt     = abt;
    sbq.push_back(w);
  endtask

  // One valid nibble; b >= 0 means this nibble closes the segment with strobe b
  task automatic nib(input int st, input int b);
    logic [8:0] s;
    s = '0;
    if (b >= 0) s[b] = 1'b1;
    cyc(st, 1'b1, s, 1'b0);
    if (b >= 0) mSeg = '0;
    else        mSeg = mSeg + 16'd1;
    if (b == B_SDS) first = 1'b0;
    if ((b == B_SCE) && (mIdx != numLat - 8'd1)) mIdx = mIdx + 8'd1;
  endtask

  task automatic seg(input int st, input int n, input int b);
    for (int k = 0; k < n; k++) nib(st, (k == n - 1) ? b : -1);
  endtask

  task automatic stall(input int st, input int n);
    for (int i = 0; i < n; i++) cyc(st, 1'b0, 9'd0, (i == ABORT_NIB - 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(S_IDLE, 1'b0, 9'd0, 1'b0);
  endtask

  task automatic pre(input logic [7:0] num);
    CfgSlaveNum = num;
    cyc(S_PRE, 1'b1, 9'd0, 1'b0);
    numLat = num; mSeg = '0; mIdx = '0; first = 1'b1;
  endtask

  task automatic hdr();
    seg(S_DATA, first ? 4 : 1, (numLat != 0) ? B_SDS : B_DFE);
  endtask

  // Slot payload: SlaveData[0]/[1] alternate per nibble in one segment.
  // Optional stall before nibble stallAt; abortOut stops after the stall.
  task automatic slotData(input int stallAt, input int stallLen, input logic abortOut);
    for (int k = 0; k < 16; k++) begin
      int st;
      st = (k % 2 == 1) ? S_SD1 : S_SD0;
      if (k == stallAt) begin
        stall(st, stallLen);
        if (abortOut) return;
      end
      nib(st, (k == 15) ? B_SDE : -1);
    end
  endtask

  task automatic frame(input logic [7:0] num, input logic [7:0] cfgAfter,
                       input int stallSlot, input int stallAt, input int stallLen);
    pre(num);
    hdr();
    CfgSlaveNum = cfgAfter;
    for (int s = 0; s < int'(numLat); s++) begin
      if (s > 0) hdr();
      slotData((s == stallSlot) ? stallAt : -1, stallLen, 1'b0);
      seg(S_SCRC, 4, B_SCE);
    end
    seg(S_FCRC, 8, B_FCE);
    idle(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, %0d queued", sbq.size());
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; MRxDV = 1'b0; CfgSlaveNum = '0; CfgMyID = '0;
    driveState(S_IDLE);
    mSeg = '0; mIdx = '0; numLat = '0; myId = '0; first = 1'b1;
    #12;
    chk("rst_SegCnt", 32'(SegCnt), 32'd0);
    chk("rst_SlaveIdx", 32'(SlaveIdx), 32'd0);
    chk("rst_RxAbort", 32'(RxAbort), 32'd0);
    chk("rst_strobes", 32'(obsStb), 32'd0);
    @(negedge MRxClk); Reset = 1'b0;
    idle(2);

    // Numb/delay/distance frame
    pre(8'd2);
    seg(S_NUMB, 2, B_SID);
    seg(S_DELAY, 4, B_DMS);
    seg(S_DIST, 8, B_DSE);
    seg(S_DDIST, 8, B_DDE);
    idle(2);

    // Three slaves, own slot 1, 3-cycle stall inside slot 0 payload
    myId = 8'd1; CfgMyID = 8'd1;
    frame(8'd3, 8'd3, 0, 5, 3);

    // Zero slaves: header ends the data frame
    frame(8'd0, 8'd0, -1, -1, 0);

    // Slave count changed mid-frame takes effect only at the next preamble
    frame(8'd3, 8'd5, -1, -1, 0);
    frame(8'd5, 8'd5, 2, 9, 2);

    // Long MRxDV gap in slot 0 payload: one abort pulse, then back to idle
    myId = 8'd0; CfgMyID = 8'd0;
    pre(8'd2);
    hdr();
    slotData(4, 10, 1'b1);
    idle(3);

    // Fresh frame after the abort
    frame(8'd2, 8'd2, -1, -1, 0);

    // Asynchronous reset in the middle of slot 1
    myId = 8'd1; CfgMyID = 8'd1;
    pre(8'd3);
    hdr();
    slotData(-1, 0, 1'b0);
    seg(S_SCRC, 4, B_SCE);
    hdr();
    for (int k = 0; k < 6; k++) nib((k % 2 == 1) ? S_SD1 : S_SD0, -1);
    @(negedge MRxClk); #1;
    chk("pre_rst_MySlot", 32'(MySlot), 32'd1);
    Reset = 1'b1;
    #1;
    chk("arst_SegCnt", 32'(SegCnt), 32'd0);
    chk("arst_SlaveIdx", 32'(SlaveIdx), 32'd0);
    chk("arst_MySlot", 32'(MySlot), 32'd0);
    chk("arst_strobes", 32'(obsStb), 32'd0);
    chk("arst_IsLast", 32'(IsLastSlave), 32'd0);
    chk("arst_RxAbort", 32'(RxAbort), 32'd0);
    driveState(S_IDLE); MRxDV = 1'b0;
    mSeg = '0; mIdx = '0; numLat = '0; first = 1'b1;
    @(negedge MRxClk); Reset = 1'b0;
    idle(2);

    myId = 8'd0; CfgMyID = 8'd0;
    frame(8'd2, 8'd2, -1, -1, 0);

    @(negedge MRxClk); #1;
    chk("sbq_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
